gbc_vram_dma_controller: RTL

CGB VRAM DMA (HDMA) controller for the Game Boy Color core. It owns registers FF51–FF55, copies data in 16-byte blocks from a system-bus source into VRAM through the video memory bus, and stalls the CPU while it moves bytes. Two transfer modes are supported:
- **General-purpose (GDMA):** copies every block back-to-back.
- **HBlank (HDMA):** copies one block per PPU Mode 0 entry.

---
 rtl/gbc_vram_dma_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gbc_vram_dma_controller.sv
// CGB HDMA controller: owns FF51-FF55 and copies 16-byte blocks from the system
// bus into VRAM, either back-to-back (GDMA) or one block per HBlank (HDMA).
module gbc_vram_dma_controller (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ClkEn,
    input  logic [2:0]  RegAddr,
    input  logic        RegWrite,
    input  logic [7:0]  RegWData,
    output logic [7:0]  RegRData,
    input  logic [1:0]  Mode,
    input  logic        LcdOn,
    output logic        CpuHalt,
    output logic        SrcAccess,
    output logic [15:0] SrcAddress,
    input  logic [7:0]  SrcData,
    input  logic        SrcDataReady,
    output logic        VramAccess,
    output logic        VramWrite,
    output logic [12:0] VramAddress,
    output logic [7:0]  VramData,
    input  logic        VramReady
);

    typedef enum logic [1:0] {IDLE, HB_WAIT, FETCH, STORE} state_t;

    state_t      state;
    logic [7:0]  src_hi;
    logic [3:0]  src_lo;
    logic [4:0]  dst_hi;
    logic [3:0]  dst_lo;
    logic [15:0] src_cnt;
    logic [12:0] dst_cnt;
    logic [3:0]  byte_cnt;
    logic [6:0]  blocks_m1;
    logic        hblank;
    logic        cancel_pend;
    logic        cancelled;
    logic [1:0]  mode_q;
    logic [7:0]  data_q;

    logic hdma5_wr;
    logic cancel_req;
    logic mode_entry;

    assign hdma5_wr   = RegWrite && (RegAddr == 3'd5);
    assign cancel_req = hdma5_wr && !RegWData[7] && hblank;
    assign mode_entry = LcdOn && (Mode == 2'd0) && (mode_q != 2'd0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            src_hi      <= '0;
            src_lo      <= '0;
            dst_hi      <= '0;
            dst_lo      <= '0;
            src_cnt     <= '0;
            dst_cnt     <= '0;
            byte_cnt    <= '0;
            blocks_m1   <= '0;
            hblank      <= 1'b0;
            cancel_pend <= 1'b0;
            cancelled   <= 1'b0;
            mode_q      <= '0;
            data_q      <= '0;
        end else if (ClkEn) begin
            mode_q <= Mode;
            if (RegWrite) begin
                case (RegAddr)
                    3'd1:    src_hi <= RegWData;
                    3'd2:    src_lo <= RegWData[7:4];
                    3'd3:    dst_hi <= RegWData[4:0];
                    3'd4:    dst_lo <= RegWData[7:4];
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (hdma5_wr) begin
                        src_cnt     <= {src_hi, src_lo, 4'h0};
                        dst_cnt     <= {dst_hi, dst_lo, 4'h0};
                        byte_cnt    <= '0;
                        blocks_m1   <= RegWData[6:0];
                        hblank      <= RegWData[7];
                        cancel_pend <= 1'b0;
                        cancelled   <= 1'b0;
                        // HBlank start gets an immediate block if already in Mode 0 or LCD is off
                        if (!RegWData[7] || !LcdOn || (Mode == 2'd0))
                            state <= FETCH;
                        else
                            state <= HB_WAIT;
                    end
                end
                HB_WAIT: begin
                    if (cancel_req) begin
                        state     <= IDLE;
                        cancelled <= 1'b1;
                    end else if (mode_entry) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (cancel_req)
                        cancel_pend <= 1'b1;
                    if (SrcDataReady) begin
                        data_q  <= SrcData;
                        src_cnt <= src_cnt + 16'd1;
                        state   <= STORE;
                    end
                end
                STORE: begin
                    if (cancel_req)
                        cancel_pend <= 1'b1;
                    if (VramReady) begin
                        dst_cnt  <= dst_cnt + 13'd1;
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'hF) begin
                            blocks_m1 <= blocks_m1 - 7'd1;
                            if (blocks_m1 == 7'd0) begin
                                state <= IDLE;
                            end else if (cancel_pend || cancel_req) begin
                                state       <= IDLE;
                                cancelled   <= 1'b1;
                                cancel_pend <= 1'b0;
                            end else if (hblank) begin
                                state <= HB_WAIT;
                            end else begin
                                state <= FETCH;
                            end
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the read mux assigns its default first so no path leaves RegRData
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        RegRData = 8'hFF;
        if (RegAddr == 3'd5) begin
            if (state != IDLE)
                RegRData = {1'b0, blocks_m1};
            else if (cancelled)
                RegRData = {1'b1, blocks_m1};
        end
    end

    assign CpuHalt     = (state == FETCH) || (state == STORE);
    assign SrcAccess   = (state == FETCH);
    assign SrcAddress  = src_cnt;
    assign VramAccess  = (state == STORE);
    assign VramWrite   = (state == STORE);
    assign VramAddress = dst_cnt;
    assign VramData    = data_q;

endmodule
